// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit side of the I2C-to-UART bridge:
// transmitter FSM state encoding, 8N1 frame constants and a small helper
// for detecting the final data bit of a frame.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Transmitter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // 8N1 frame constants
  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // True when the given bit index is the last data bit of the frame
  function automatic logic is_last_data_bit(input logic [2:0] idx);
    return (idx == 3'(DATA_BITS - 1));
  endfunction

endpackage

// File: rtl/uart_tx_bridge_byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Synchronous byte FIFO with show-ahead read data.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset (pointers/count cleared)
//   wr_en    in   write request; accepted when not full or when a read
//                 happens on the same edge
//   wr_data  in   byte to store
//   rd_en    in   pop the head entry (ignored when empty)
//   rd_data  out  head entry, valid whenever empty is low
//   full     out  occupancy equals DEPTH
//   empty    out  occupancy is zero
//   count    out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          wr_acc_s;
  logic          rd_acc_s;

  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == {CW{1'b0}});
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];

  // A write into a full FIFO is still accepted when the head leaves on the same edge
  assign wr_acc_s = wr_en && (!full || rd_en);
  assign rd_acc_s = rd_en && !empty;

  // Storage array; data needs no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_bridge.sv
// ---------------------------------------------------------------------------
// uart_tx_bridge
// Buffers bytes received by the I2C slave in a small FIFO and serialises
// them as 8N1 UART, LSB first. Consecutive frames are sent back to back
// with no idle gap while the FIFO holds data.
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset; line returns idle at once
//   byte_in     in   data byte from the I2C slave
//   byte_valid  in   one-cycle strobe qualifying byte_in
//   ovf_clr     in   synchronous clear of the overflow flag
//   tx          out  registered UART line, idle high
//   busy        out  transmitter active or FIFO non-empty
//   fifo_count  out  FIFO occupancy
//   overflow    out  sticky: a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_tx_bridge
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  input  logic                          ovf_clr,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_r;
  tx_state_e         state_nxt_s;
  logic [BAUD_W-1:0] baud_cnt_r;
  logic [BAUD_W-1:0] baud_nxt_s;
  logic [2:0]        bit_idx_r;
  logic [2:0]        bit_idx_nxt_s;
  logic [7:0]        shift_r;
  logic [7:0]        shift_nxt_s;
  logic              tx_r;
  logic              tx_nxt_s;
  logic              busy_r;
  logic              busy_nxt_s;
  logic              overflow_r;
  logic              overflow_nxt_s;

  logic              pop_s;
  logic              wr_acc_s;
  logic              drop_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [7:0]        fifo_rd_data_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (byte_valid),
    .wr_data (byte_in),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Mirror of the FIFO accept rule, used to predict next occupancy for busy
  assign wr_acc_s = byte_valid && (!fifo_full_s || pop_s);
  assign drop_s   = byte_valid && fifo_full_s && !pop_s;

  // Next-state logic; tx_nxt_s is the line level for the cycle after the edge
  always_comb begin
    state_nxt_s   = state_r;
    baud_nxt_s    = baud_cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    tx_nxt_s      = IDLE_LVL;
    pop_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          shift_nxt_s = fifo_rd_data_s;
          baud_nxt_s  = {BAUD_W{1'b0}};
          state_nxt_s = ST_START;
          tx_nxt_s    = START_LVL;
        end else begin
          tx_nxt_s    = IDLE_LVL;
        end
      end
      ST_START: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_nxt_s    = {BAUD_W{1'b0}};
          bit_idx_nxt_s = 3'd0;
          state_nxt_s   = ST_DATA;
          tx_nxt_s      = shift_r[0];
        end else begin
          baud_nxt_s    = baud_cnt_r + BAUD_W'(1);
          tx_nxt_s      = START_LVL;
        end
      end
      ST_DATA: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_nxt_s  = {BAUD_W{1'b0}};
          shift_nxt_s = {1'b0, shift_r[7:1]};
          if (is_last_data_bit(bit_idx_r)) begin
            state_nxt_s   = ST_STOP;
            tx_nxt_s      = STOP_LVL;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
            tx_nxt_s      = shift_nxt_s[0];
          end
        end else begin
          baud_nxt_s = baud_cnt_r + BAUD_W'(1);
          tx_nxt_s   = shift_r[0];
        end
      end
      ST_STOP: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_nxt_s = {BAUD_W{1'b0}};
          // Chain straight into the next start bit when data is waiting
          if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            shift_nxt_s = fifo_rd_data_s;
            state_nxt_s = ST_START;
            tx_nxt_s    = START_LVL;
          end else begin
            state_nxt_s = ST_IDLE;
            tx_nxt_s    = IDLE_LVL;
          end
        end else begin
          baud_nxt_s = baud_cnt_r + BAUD_W'(1);
          tx_nxt_s   = STOP_LVL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        baud_nxt_s  = {BAUD_W{1'b0}};
        tx_nxt_s    = IDLE_LVL;
      end
    endcase
  end

  // Next busy and overflow values; a drop on the same edge as a clear keeps the flag set
  always_comb begin
    cnt_nxt_s = fifo_count_s;
    case ({wr_acc_s, pop_s})
      2'b10:   cnt_nxt_s = fifo_count_s + CNT_W'(1);
      2'b01:   cnt_nxt_s = fifo_count_s - CNT_W'(1);
      default: cnt_nxt_s = fifo_count_s;
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE) || (cnt_nxt_s != {CNT_W{1'b0}});
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
    end else if (ovf_clr) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
  end

  // Transmitter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      baud_cnt_r <= baud_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      shift_r    <= shift_nxt_s;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r       <= IDLE_LVL;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      tx_r       <= tx_nxt_s;
      busy_r     <= busy_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign fifo_count = fifo_count_s;

endmodule
